// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the memory responder: bus widths, burst geometry,
// the tag bit that marks a write, and the responder state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH  = 13;
    localparam int BURST_LEN      = 8;
    localparam int WRITE_BIT      = BUS_TAG_WIDTH - 1;
    localparam int LINE_SHIFT     = 6;     // 64-byte line: addr[5:0] is the byte offset

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Request/response bus between the core (master) and the memory responder
// (slave).
//   bus_reqcyc/bus_req/bus_reqtag : request beat valid, addr/data, tag
//   bus_reqack                     : responder accepts request beat
//   bus_respcyc/bus_resp/bus_resptag : response beat valid, data, tag
//   bus_respack                    : initiator accepts response beat
// ----------------------------------------------------------------------------
interface mem_responder_if;
    import bus_pkg::*;

    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

// File: rtl/mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
// Word array backing the responder. One synchronous write port, one
// asynchronous read port. Contents are never reset.
//   clk        : clock
//   we_i       : write enable
//   wr_idx_i   : write word index
//   wr_data_i  : write data
//   rd_idx_i   : read word index
//   rd_data_o  : read data (combinational)
// ----------------------------------------------------------------------------
module mem_array #(
    parameter int WORDS = 4096,
    parameter int AW    = 12,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Target end of the core's system bus. Accepts line read/write requests,
// serves them from mem_array after LATENCY idle cycles and returns tagged
// response beats under a per-beat acknowledge.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : request/response bus (slave side)
//
// state | meaning
// IDLE  | waiting for an address beat
// WDATA | collecting BURST_LEN write data beats
// WAIT  | latency down-counter running
// RESP  | presenting read beats or the single write completion beat
// ----------------------------------------------------------------------------
module mem_responder
    import bus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CW    = $clog2(BURST_LEN);
    localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LINES = MEM_WORDS / BURST_LEN;
    localparam logic [LW-1:0] LAT_LOAD = (LATENCY > 0) ? LW'(LATENCY - 1) : '0;

    state_e                    state_q, state_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [AW-1:0]             base_q, base_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [LW-1:0]             lat_q, lat_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic                      we;
    logic [AW-1:0]             wr_idx;
    logic [AW-1:0]             rd_idx;
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                      req_done;
    logic                      go_resp;

    // Line number wraps modulo the number of lines, so a line never straddles
    // the end of the array.
    function automatic logic [AW-1:0] line_base(input logic [BUS_DATA_WIDTH-1:0] addr);
        logic [BUS_DATA_WIDTH-1:0] line_no;
        line_no = (addr >> LINE_SHIFT) % BUS_DATA_WIDTH'(LINES);
        return AW'(line_no * BUS_DATA_WIDTH'(BURST_LEN));
    endfunction

    mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW),
        .DW    (BUS_DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .we_i      (we),
        .wr_idx_i  (wr_idx),
        .wr_data_i (bus.bus_req),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    assign we     = (state_q == WDATA) && bus.bus_reqcyc;
    assign wr_idx = base_q + AW'(cnt_q);

    // Read index for the beat loaded at the next edge: beat 0 straight from
    // the address beat (zero latency), beat 0 from WAIT, or the next beat in RESP.
    always_comb begin
        rd_idx = base_q;
        if (state_q == IDLE) begin
            rd_idx = line_base(bus.bus_req);
        end else if (state_q == RESP) begin
            rd_idx = base_q + AW'(cnt_q) + AW'(1);
        end
    end

    assign bus.bus_reqack  = bus.bus_reqcyc && ((state_q == IDLE) || (state_q == WDATA));
    assign bus.bus_respcyc = respcyc_q;
    assign bus.bus_resp    = resp_q;
    assign bus.bus_resptag = resptag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        req_done  = 1'b0;
        go_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.bus_reqcyc) begin
                    tag_d  = bus.bus_reqtag;
                    base_d = line_base(bus.bus_req);
                    cnt_d  = '0;
                    if (bus.bus_reqtag[WRITE_BIT]) begin
                        state_d = WDATA;
                    end else begin
                        req_done = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (bus.bus_reqcyc) begin
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        req_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    go_resp = 1'b1;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESP: begin
                if (bus.bus_respack) begin
                    if (tag_q[WRITE_BIT] || (cnt_q == CW'(BURST_LEN - 1))) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        resp_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_done) begin
            if (LATENCY == 0) begin
                go_resp = 1'b1;
            end else begin
                state_d = WAIT;
                lat_d   = LAT_LOAD;
            end
        end

        // First response beat uses the captured (or just-captured) tag/base.
        if (go_resp) begin
            state_d   = RESP;
            cnt_d     = '0;
            respcyc_d = 1'b1;
            resptag_d = tag_d;
            resp_d    = tag_d[WRITE_BIT] ? '0 : rd_data;
        end
    end

endmodule
